// File: rtl/simt_regfile_pkg.sv
// Shared definitions for the multi-thread register file: special register
// offsets, the write request record and the special-address test.
package simt_regfile_pkg;

  // Special registers sit at the top of each thread's register space.
  localparam int SPEC_BLOCK_OFS = 3;
  localparam int SPEC_TPB_OFS   = 2;
  localparam int SPEC_TID_OFS   = 1;

  // Request fields are sized for the widest supported configuration.
  localparam int REQ_AW = 8;
  localparam int REQ_DW = 64;

  typedef struct packed {
    logic              valid;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] data;
  } wr_req_t;

  function automatic logic is_special(input logic [REQ_AW-1:0] addr, input int num_regs);
    return (int'(addr) >= (num_regs - SPEC_BLOCK_OFS));
  endfunction

endpackage

// File: rtl/simt_reg_bank.sv
// One thread's register context: storage, pending-load busy bits, the ALU and
// load write ports, and registered dual read with write-first bypass.
module simt_reg_bank
  import simt_regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int TID      = 0,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr_a,
  input  logic [AW-1:0]       rd_addr_b,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                pend_set,
  input  logic [AW-1:0]       pend_addr,
  input  logic                ld_valid,
  input  logic [AW-1:0]       ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic [DATA_W-1:0]   block_id,
  input  logic [DATA_W-1:0]   threads_per_block,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic [NUM_REGS-1:0] busy
);

  localparam logic [AW-1:0] BLOCK_ADDR = AW'(NUM_REGS - SPEC_BLOCK_OFS);
  localparam logic [AW-1:0] TPB_ADDR   = AW'(NUM_REGS - SPEC_TPB_OFS);
  localparam logic [AW-1:0] TID_ADDR   = AW'(NUM_REGS - SPEC_TID_OFS);

  logic [DATA_W-1:0]   mem_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [DATA_W-1:0]   rd_a_r;
  logic [DATA_W-1:0]   rd_b_r;
  wr_req_t             ld_req_s;
  wr_req_t             alu_req_s;
  logic                pend_hit_s;
  logic                unused_req_s;
  logic [AW-1:0]       rd_addr_s [2];
  logic [DATA_W-1:0]   rd_word_s [2];

  assign rd_addr_s[0] = rd_addr_a;
  assign rd_addr_s[1] = rd_addr_b;

  // Form write requests; a load to the same register drops the ALU write.
  always_comb begin
    ld_req_s.valid  = ld_valid & ~is_special(REQ_AW'(ld_addr), NUM_REGS);
    ld_req_s.addr   = REQ_AW'(ld_addr);
    ld_req_s.data   = REQ_DW'(ld_data);
    alu_req_s.valid = wr_en & ~is_special(REQ_AW'(wr_addr), NUM_REGS)
                      & ~(ld_req_s.valid & (ld_addr == wr_addr));
    alu_req_s.addr  = REQ_AW'(wr_addr);
    alu_req_s.data  = REQ_DW'(wr_data);
    pend_hit_s      = pend_set & ~is_special(REQ_AW'(pend_addr), NUM_REGS);
  end

  assign unused_req_s = ^{ld_req_s, alu_req_s};

  // Read mux: specials from inputs, otherwise the post-write value of the register.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word_s[p] = {DATA_W{1'b0}};
      case (rd_addr_s[p])
        BLOCK_ADDR: rd_word_s[p] = block_id;
        TPB_ADDR:   rd_word_s[p] = threads_per_block;
        TID_ADDR:   rd_word_s[p] = DATA_W'(TID);
        default: begin
          if (ld_req_s.valid && (ld_req_s.addr == REQ_AW'(rd_addr_s[p]))) begin
            rd_word_s[p] = ld_req_s.data[DATA_W-1:0];
          end else if (alu_req_s.valid && (alu_req_s.addr == REQ_AW'(rd_addr_s[p]))) begin
            rd_word_s[p] = alu_req_s.data[DATA_W-1:0];
          end else begin
            rd_word_s[p] = mem_r[rd_addr_s[p]];
          end
        end
      endcase
    end
  end

  // Register storage update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld_req_s.valid && (ld_req_s.addr == REQ_AW'(i))) begin
          mem_r[i] <= ld_req_s.data[DATA_W-1:0];
        end else if (alu_req_s.valid && (alu_req_s.addr == REQ_AW'(i))) begin
          mem_r[i] <= alu_req_s.data[DATA_W-1:0];
        end
      end
    end
  end

  // Pending-load scoreboard; a set overrides a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (pend_hit_s && (REQ_AW'(pend_addr) == REQ_AW'(i))) begin
          busy_r[i] <= 1'b1;
        end else if (ld_req_s.valid && (ld_req_s.addr == REQ_AW'(i))) begin
          busy_r[i] <= 1'b0;
        end
      end
    end
  end

  // Read output registers, held while rd_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_a_r <= {DATA_W{1'b0}};
      rd_b_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_a_r <= rd_word_s[0];
      rd_b_r <= rd_word_s[1];
    end
  end

  assign rd_data_a = rd_a_r;
  assign rd_data_b = rd_b_r;
  assign busy      = busy_r;

endmodule

// File: rtl/simt_regfile.sv
// Multi-thread register file top: one bank per thread, active-mask fan-out of
// pend_set, and the scheduler hazard reduction.
module simt_regfile
  import simt_regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int THREADS  = 4,
  parameter int NUM_REGS = 16,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [THREADS-1:0]        active_mask,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr_a,
  input  logic [AW-1:0]             rd_addr_b,
  output logic [THREADS*DATA_W-1:0] rd_data_a,
  output logic [THREADS*DATA_W-1:0] rd_data_b,
  input  logic [THREADS-1:0]        wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [THREADS*DATA_W-1:0] wr_data,
  input  logic                      pend_set,
  input  logic [AW-1:0]             pend_addr,
  input  logic [THREADS-1:0]        ld_valid,
  input  logic [THREADS*AW-1:0]     ld_addr,
  input  logic [THREADS*DATA_W-1:0] ld_data,
  input  logic [DATA_W-1:0]         block_id,
  input  logic [DATA_W-1:0]         threads_per_block,
  output logic                      hazard
);

  logic [NUM_REGS-1:0] busy_s [THREADS];
  logic                hazard_s;

  for (genvar t = 0; t < THREADS; t++) begin : g_thread
    simt_reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .TID      (t)
    ) u_bank (
      .clk               (clk),
      .reset             (reset),
      .rd_en             (rd_en),
      .rd_addr_a         (rd_addr_a),
      .rd_addr_b         (rd_addr_b),
      .wr_en             (wr_en[t]),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data[t*DATA_W +: DATA_W]),
      .pend_set          (pend_set & active_mask[t]),
      .pend_addr         (pend_addr),
      .ld_valid          (ld_valid[t]),
      .ld_addr           (ld_addr[t*AW +: AW]),
      .ld_data           (ld_data[t*DATA_W +: DATA_W]),
      .block_id          (block_id),
      .threads_per_block (threads_per_block),
      .rd_data_a         (rd_data_a[t*DATA_W +: DATA_W]),
      .rd_data_b         (rd_data_b[t*DATA_W +: DATA_W]),
      .busy              (busy_s[t])
    );
  end

  // Hazard uses registered busy state only, so a same-cycle return does not hide it.
  always_comb begin
    hazard_s = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      hazard_s = hazard_s | (active_mask[t] &
                 (busy_s[t][rd_addr_a] | busy_s[t][rd_addr_b] | busy_s[t][wr_addr]));
    end
  end

  assign hazard = hazard_s;

endmodule

// File: tb/tb_simt_regfile.sv
// Self-checking bench for simt_regfile: directed scenarios then random traffic,
// checked against an array-based behavioural model of the register file.
module tb_simt_regfile;

  localparam int DW = 8;
  localparam int T  = 4;
  localparam int NR = 16;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [T-1:0]    active_mask;
  logic            rd_en;
  logic [AW-1:0]   rd_addr_a, rd_addr_b;
  logic [T*DW-1:0] rd_data_a, rd_data_b;
  logic [T-1:0]    wr_en;
  logic [AW-1:0]   wr_addr;
  logic [T*DW-1:0] wr_data;
  logic            pend_set;
  logic [AW-1:0]   pend_addr;
  logic [T-1:0]    ld_valid;
  logic [T*AW-1:0] ld_addr;
  logic [T*DW-1:0] ld_data;
  logic [DW-1:0]   block_id, threads_per_block;
  logic            hazard;

  logic [DW-1:0] m_reg [T][NR];
  bit            m_busy [T][NR];
  logic [DW-1:0] m_a [T];
  logic [DW-1:0] m_b [T];
  int total = 0;
  int bad   = 0;

  simt_regfile #(.DATA_W(DW), .THREADS(T), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .active_mask(active_mask), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .block_id(block_id), .threads_per_block(threads_per_block),
    .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input int t, input int a);
    if (a == NR - 3) return block_id;
    else if (a == NR - 2) return threads_per_block;
    else if (a == NR - 1) return DW'(t);
    else return m_reg[t][a];
  endfunction

  task automatic clear_model();
    for (int t = 0; t < T; t++) begin
      m_a[t] = '0;
      m_b[t] = '0;
      for (int r = 0; r < NR; r++) begin
        m_reg[t][r]  = '0;
        m_busy[t][r] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    active_mask = '0; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0;
    ld_valid = '0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic check_reads();
    for (int t = 0; t < T; t++) begin
      chk($sformatf("rd_a[%0d]", t), 32'(rd_data_a[t*DW +: DW]), 32'(m_a[t]));
      chk($sformatf("rd_b[%0d]", t), 32'(rd_data_b[t*DW +: DW]), 32'(m_b[t]));
    end
  endtask

  // One clock: check hazard against the model, advance the model, check reads.
  task automatic step();
    logic eh;
    int wa, pa, la;
    #1;
    eh = 1'b0;
    for (int t = 0; t < T; t++)
      if (active_mask[t] && (m_busy[t][rd_addr_a] || m_busy[t][rd_addr_b] || m_busy[t][wr_addr]))
        eh = 1'b1;
    chk("hazard", 32'(hazard), 32'(eh));
    wa = int'(wr_addr);
    pa = int'(pend_addr);
    for (int t = 0; t < T; t++) begin
      la = int'(ld_addr[t*AW +: AW]);
      if (wr_en[t] && wa < NR - 3) m_reg[t][wa] = wr_data[t*DW +: DW];
      if (ld_valid[t] && la < NR - 3) begin
        m_reg[t][la]  = ld_data[t*DW +: DW];
        m_busy[t][la] = 1'b0;
      end
      if (pend_set && active_mask[t] && pa < NR - 3) m_busy[t][pa] = 1'b1;
    end
    if (rd_en) begin
      for (int t = 0; t < T; t++) begin
        m_a[t] = m_read(t, int'(rd_addr_a));
        m_b[t] = m_read(t, int'(rd_addr_b));
      end
    end
    @(posedge clk);
    #1;
    check_reads();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    clear_model();
    chk("reset_hazard", 32'(hazard), 32'd0);
    check_reads();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle();
    block_id = 8'd5;
    threads_per_block = 8'd4;
    do_reset();
    step();

    // Specials and a plain register after reset.
    rd_en = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd13;
    step();
    chk("t2_r0", 32'(rd_data_a[23:16]), 32'd0);
    chk("t2_r13", 32'(rd_data_b[23:16]), 32'd5);
    rd_addr_a = 4'd14; rd_addr_b = 4'd15;
    step();
    chk("t2_r14", 32'(rd_data_a[23:16]), 32'd4);
    chk("t2_r15", 32'(rd_data_b[23:16]), 32'd2);

    // Masked ALU write, read one cycle later.
    idle(); wr_en = 4'b0101; wr_addr = 4'd3; wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    idle(); rd_en = 1'b1; rd_addr_a = 4'd3;
    step();
    chk("wr_t0", 32'(rd_data_a[7:0]), 32'h10);
    chk("wr_t1", 32'(rd_data_a[15:8]), 32'h00);
    chk("wr_t2", 32'(rd_data_a[23:16]), 32'h12);
    chk("wr_t3", 32'(rd_data_a[31:24]), 32'h00);

    // Write-first bypass, and a write to a special register.
    idle(); wr_en = 4'b1111; wr_addr = 4'd7; wr_data = {4{8'hAA}};
    rd_en = 1'b1; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    step();
    chk("bypass_t1", 32'(rd_data_a[15:8]), 32'hAA);
    idle(); wr_en = 4'b1111; wr_addr = 4'd13; wr_data = {4{8'h77}};
    rd_en = 1'b1; rd_addr_a = 4'd13;
    step();
    chk("special_ro", 32'(rd_data_a[7:0]), 32'd5);

    // Pending load scoreboard.
    idle(); active_mask = 4'b1111; pend_set = 1'b1; pend_addr = 4'd4;
    step();
    idle(); active_mask = 4'b1111; rd_addr_a = 4'd4;
    #1 chk("haz_set", 32'(hazard), 32'd1);
    step();
    ld_valid = 4'b0111; ld_addr = {4{4'd4}}; ld_data = {8'h43, 8'h42, 8'h41, 8'h40};
    step();
    ld_valid = 4'b0000;
    #1 chk("haz_partial", 32'(hazard), 32'd1);
    ld_valid = 4'b1000;
    step();
    ld_valid = 4'b0000; rd_en = 1'b1;
    #1 chk("haz_clear", 32'(hazard), 32'd0);
    step();
    chk("ld_t3", 32'(rd_data_a[31:24]), 32'h43);
    chk("ld_t0", 32'(rd_data_a[7:0]), 32'h40);

    // Load beats ALU on the same register.
    idle(); wr_en = 4'b0010; wr_addr = 4'd6; wr_data = {8'h00, 8'h00, 8'h11, 8'h00};
    ld_valid = 4'b0010; ld_addr = {4'd0, 4'd0, 4'd6, 4'd0}; ld_data = {8'h00, 8'h00, 8'h22, 8'h00};
    rd_en = 1'b1; rd_addr_a = 4'd6;
    step();
    chk("prio_bypass", 32'(rd_data_a[15:8]), 32'h22);
    idle(); rd_en = 1'b1; rd_addr_a = 4'd6;
    step();
    chk("prio_store", 32'(rd_data_a[15:8]), 32'h22);

    // Set beats a same-cycle clear.
    idle(); active_mask = 4'b0010; pend_set = 1'b1; pend_addr = 4'd9;
    step();
    idle(); active_mask = 4'b0010; pend_set = 1'b1; pend_addr = 4'd9;
    ld_valid = 4'b0010; ld_addr = {4'd0, 4'd0, 4'd9, 4'd0}; ld_data = {8'h00, 8'h00, 8'h99, 8'h00};
    step();
    idle(); active_mask = 4'b1111; rd_addr_a = 4'd9;
    #1 chk("haz_setwins", 32'(hazard), 32'd1);
    step();

    // Reset while busy, then a late load return and normal operation.
    do_reset();
    ld_valid = 4'b0010; ld_addr = {4'd0, 4'd0, 4'd9, 4'd0}; ld_data = {8'h00, 8'h00, 8'h5A, 8'h00};
    rd_en = 1'b1;
    step();
    chk("late_ld", 32'(rd_data_a[15:8]), 32'h5A);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      active_mask = 4'($urandom);
      rd_en       = 1'($urandom);
      rd_addr_a   = 4'($urandom);
      rd_addr_b   = 4'($urandom);
      wr_en       = 4'($urandom);
      wr_addr     = 4'($urandom);
      wr_data     = 32'($urandom);
      pend_set    = ($urandom_range(0, 3) == 0);
      pend_addr   = 4'($urandom);
      ld_valid    = 4'($urandom);
      ld_addr     = 16'($urandom);
      ld_data     = 32'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        block_id          = 8'($urandom);
        threads_per_block = 8'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simt_regfile.md
# simt_regfile

Parametrised, multi-thread register file for one core, a successor to the single-thread 8-bit register file. It holds `THREADS` lockstep thread contexts with `NUM_REGS` registers each; the top three registers are read-only specials. It adds registered dual-port reads with write-first bypass, per-thread write masks, and a second per-thread write port for asynchronous load returns. A per-register pending-load scoreboard drives a hazard output for the scheduler.

## Interface
- `DATA_W`, 8: register width in bits.
- `THREADS`, 4: thread contexts; must be ≥1.
- `NUM_REGS`, 16: registers per thread; must be ≥4. `AW = $clog2(NUM_REGS)`.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `active_mask` in `THREADS`: threads enabled for this instruction.
- `rd_en` in 1: capture a read this cycle.
- `rd_addr_a`, `rd_addr_b` in `AW`: read addresses, shared by all threads.
- `rd_data_a`, `rd_data_b` out `THREADS`×`DATA_W`: registered read data, one word per thread.
- `wr_en` in `THREADS`: ALU write enable per thread.
- `wr_addr` in `AW`: ALU destination register, shared.
- `wr_data` in `THREADS`×`DATA_W`: ALU write data.
- `pend_set` in 1: mark `pend_addr` busy for the threads in `active_mask` (load issued).
- `pend_addr` in `AW`: load destination register.
- `ld_valid` in `THREADS`: load return strobe per thread.
- `ld_addr` in `THREADS`×`AW`: load return register per thread.
- `ld_data` in `THREADS`×`DATA_W`: load return data.
- `block_id`, `threads_per_block` in `DATA_W`: special register sources.
- `hazard` out 1: combinational; a read or destination register is busy in an active thread.

## Operation
- Special registers are read-only:
  - `NUM_REGS-3` reads `block_id`.
  - `NUM_REGS-2` reads `threads_per_block`.
  - `NUM_REGS-1` reads the thread's local index t, zero-extended to `DATA_W`.
- Writes, `pend_set` and `ld_valid` that target a special register are ignored and change no state.
- ALU write: on a clock edge with `wr_en[t]`, `reg[t][wr_addr]` takes `wr_data[t]`. `active_mask` does not gate this write; the issuing logic owns `wr_en`.
- Load write: on a clock edge with `ld_valid[t]`, `reg[t][ld_addr[t]]` takes `ld_data[t]` and `busy[t][ld_addr[t]]` clears.
- Both write ports hitting the same thread and register in one cycle: the load write wins and the ALU write is dropped. Different registers: both writes happen.
- `pend_set` sets `busy[t][pend_addr]` for every t in `active_mask`. If a set and a clear hit the same bit in one cycle, the set wins.
- `pend_set` on an already-busy bit leaves it set; there is no counting.
- `hazard` is the OR, over t in `active_mask`, of `busy[t][rd_addr_a] | busy[t][rd_addr_b] | busy[t][wr_addr]`.
- `hazard` is independent of `rd_en`. The busy state it uses is the registered state, with no same-cycle clear bypass.

## Timing
- Read latency is 1 cycle. When `rd_en` is high at edge N, `rd_data_*` holds the values from edge N until the next `rd_en` edge. When `rd_en` is low, the outputs hold.
- Bypass is write-first. If a write (load or ALU, using the priority above) to the read address lands on the same edge as the capture, `rd_data` shows the new value.
- Write-to-read through storage with no bypass: write at edge N, read captured at edge N+1 returns the new value.
- Special registers are sampled from the inputs at the capture edge.
- Reset clears all registers, all busy bits, and `rd_data_a`/`rd_data_b` to 0. `hazard` becomes 0 once the busy bits clear.
- Reset asserted mid-load drops the pending state. A later `ld_valid` still writes its data and clears an already-clear bit.

## Structure
- Package `simt_regfile_pkg`:
  - `localparam` indices for the three special registers, as offsets from `NUM_REGS`.
  - Function `is_special(addr, num_regs)`.
  - Typedef for the per-thread write request {valid, addr, data}.
- Sub-module `simt_reg_bank`, one instance per thread (generate loop). It contains:
  - the storage array;
  - the busy vector;
  - the two write ports and their priority;
  - the read mux with bypass and specials;
  - the output registers.
- The top level does only the mask fan-out and the `hazard` OR-reduce.

## Test plan
- Reset, then read registers 0, 13, 14, 15 with `block_id=5`, `threads_per_block=4` → thread 2 returns 0, 5, 4, 2; both outputs are 0 before the first `rd_en`.
- `wr_en=4'b0101`, `wr_addr=3`, data {t:0x10+t}; read 3 one cycle later → threads 0 and 2 return 0x10 and 0x12, threads 1 and 3 return 0.
- Same-cycle write 0xAA and read of register 7 → `rd_data` is 0xAA on the following cycle. A write to register 13 → a read still returns `block_id`.
- `pend_set`, `pend_addr=4`, mask 4'b1111; `rd_addr_a=4` → `hazard=1`. Return `ld_valid` on threads 0–2 only → `hazard` stays 1. Return thread 3 → `hazard=0` the next cycle and the read gets the load data.
- Thread 1 has ALU write 0x11 and load return 0x22 to register 6 in the same cycle → the register reads 0x22. Simultaneous `pend_set` and `ld_valid` on the same bit → the bit stays busy.
- Assert reset while bits are busy → `hazard` drops to 0, all reads return 0, and subsequent normal operation works.
